next_pc_unit: RTL and testbench

//  Computes the next fetch address (pc_next) fed back into the program counter's pc_in each cycle.
//  - Inputs: current PC plus decoded control from the single-cycle datapath.
//  - Handles sequential, branch, jump, call (jal) and return (ret) flow.
//  - ret targets come from an internal return-address stack (RAS).
//  - A RUN/HALT state machine can freeze fetch.

---
 rtl/npc_pkg.sv | 8 +
 rtl/npc_ras.sv | 49 ++++
 rtl/next_pc_unit.sv | 69 ++++++
 tb/tb_next_pc_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared widths, defaults and select/state enums for the next-PC unit.
package npc_pkg;
  localparam int PC_W = 7;
  localparam int INSN_BYTES = 4;
  localparam int RAS_DEPTH = 4;
  typedef enum logic [2:0] {SEL_HOLD, SEL_RET, SEL_JMP, SEL_BR, SEL_SEQ} npc_sel_e;
  typedef enum logic {ST_RUN, ST_HALT} npc_state_e;
endpackage

// File: rtl/npc_ras.sv
// npc_ras: circular return-address LIFO; a push when full overwrites the oldest entry.
module npc_ras #(
  parameter int W = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp;
  logic [CW-1:0] cnt_q, cnt_d;
  assign rp = wp_q - PW'(1);
  assign top = mem_q[rp];
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  // When full, wp_q already points at the oldest slot, so a push overwrites it.
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = din;
      wp_d = wp_q + PW'(1);
      cnt_d = full ? cnt_q : cnt_q + CW'(1);
    end else if (pop && !empty) begin
      wp_d = rp;
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: next fetch address with branch/jump/call/return, RAS and RUN/HALT FSM.
// Optional NPC_ALIGN_CHECK_EN: misaligned pc_cur forces pc_next=0 and sets sticky misalign.
module next_pc_unit #(
  parameter int PC_W = npc_pkg::PC_W,
  parameter int RAS_DEPTH = npc_pkg::RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch,
  input  logic            zero,
  input  logic [4:0]      br_off,
  input  logic            jump,
  input  logic            jal,
  input  logic            ret,
  input  logic [4:0]      j_target,
  output logic [PC_W-1:0] pc_next,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err,
  output logic            misalign
);
  import npc_pkg::*;
  npc_state_e state_q, state_d;
  npc_sel_e sel;
  logic ras_err_q, ras_err_d, misalign_q, misalign_d, bad, push, pop;
  logic [PC_W-1:0] seq, ras_top;
`ifdef NPC_ALIGN_CHECK_EN
  assign bad = !stall && pc_cur[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif
  npc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(seq),
    .top(ras_top), .empty(ras_empty), .full(ras_full)
  );
  always_comb begin
    seq = pc_cur + PC_W'(INSN_BYTES);
    sel = (stall || halt || state_q == ST_HALT) ? SEL_HOLD :
          ret ? SEL_RET : (jal || jump) ? SEL_JMP : (branch && zero) ? SEL_BR : SEL_SEQ;
    pc_next = (reset || bad) ? '0 :
              sel == SEL_HOLD ? pc_cur :
              sel == SEL_RET ? (ras_empty ? '0 : ras_top) :
              sel == SEL_JMP ? PC_W'({j_target, 2'b00}) :
              sel == SEL_BR ? seq + (PC_W'($signed(br_off)) << 2) : seq;
    push = !reset && !bad && sel == SEL_JMP && jal;
    pop = !reset && !bad && sel == SEL_RET;
    state_d = (state_q == ST_RUN && halt && !stall && !bad) ? ST_HALT : state_q;
    ras_err_d = ras_err_q | (pop & ras_empty);
    misalign_d = misalign_q | bad;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ras_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ras_err_q <= ras_err_d;
      misalign_q <= misalign_d;
    end
  end
  assign halted = state_q == ST_HALT;
  assign ras_err = ras_err_q;
  assign misalign = misalign_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: vector table, directed call/return/halt sequences and random run vs a queue model.
module tb_next_pc_unit;
  localparam int DEPTH = 4;
  logic clk = 0, reset, stall, halt, branch, zero, jump, jal, ret;
  logic [6:0] pc_cur, pc_next;
  logic [4:0] br_off, j_target;
  logic halted, ras_empty, ras_full, ras_err, misalign;
  int checks = 0, errors = 0;
  int m_q[$];
  bit m_halted = 0, m_err = 0;

  next_pc_unit dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall), .halt(halt),
    .branch(branch), .zero(zero), .br_off(br_off), .jump(jump), .jal(jal),
    .ret(ret), .j_target(j_target), .pc_next(pc_next), .halted(halted),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err), .misalign(misalign)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int predict();
    int p = int'(pc_cur);
    if (reset) return 0;
    if (stall || m_halted || halt) return p;
    if (ret) return m_q.size() ? m_q[$] : 0;
    if (jal || jump) return int'(j_target) * 4;
    if (branch && zero) return (p + 4 + int'($signed(br_off)) * 4) & 'h7f;
    return (p + 4) & 'h7f;
  endfunction

  function automatic void advance();
    if (reset) begin
      m_q.delete();
      m_halted = 0;
      m_err = 0;
    end else if (!stall && !m_halted) begin
      if (halt) m_halted = 1;
      else if (ret) begin
        if (m_q.size()) void'(m_q.pop_back());
        else m_err = 1;
      end else if (jal) begin
        if (m_q.size() == DEPTH) void'(m_q.pop_front());
        m_q.push_back((int'(pc_cur) + 4) & 'h7f);
      end
    end
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic apply(input string nm, input int lit);
    #1;
    chk({nm, "_pc"}, int'(pc_next), predict());
    if (lit >= 0) chk({nm, "_lit"}, int'(pc_next), lit);
    chk({nm, "_halted"}, int'(halted), int'(m_halted));
    chk({nm, "_empty"}, int'(ras_empty), int'(m_q.size() == 0));
    chk({nm, "_full"}, int'(ras_full), int'(m_q.size() == DEPTH));
    chk({nm, "_err"}, int'(ras_err), int'(m_err));
    chk({nm, "_misalign"}, int'(misalign), 0);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle();
    {reset, stall, halt, branch, zero, jump, jal, ret} = '0;
    br_off = 0;
    j_target = 0;
  endtask

  typedef struct {
    logic [6:0] pc;
    logic br, z;
    logic [4:0] off;
    logic jmp, stl, hlt;
    logic [4:0] jt;
    int exp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl = '{
      '{7'h10, 1, 1, 5'h1e, 0, 0, 0, 5'd0, 'h0c},
      '{7'h10, 1, 0, 5'h1e, 0, 0, 0, 5'd0, 'h14},
      '{7'h7c, 0, 0, 5'd0, 0, 0, 0, 5'd0, 'h00},
      '{7'h00, 0, 0, 5'd0, 1, 0, 0, 5'd31, 'h7c},
      '{7'h70, 1, 1, 5'd15, 0, 0, 0, 5'd0, 'h30},
      '{7'h00, 1, 1, 5'h10, 0, 0, 0, 5'd0, 'h44},
      '{7'h24, 0, 0, 5'd0, 1, 1, 0, 5'd9, 'h24},
      '{7'h18, 0, 0, 5'd0, 0, 1, 1, 5'd0, 'h18},
      '{7'h10, 1, 1, 5'd1, 1, 0, 0, 5'd3, 'h0c},
      '{7'h7f, 0, 0, 5'd0, 0, 0, 0, 5'd0, 'h03}
    };
    idle();
    pc_cur = 0;
    @(negedge clk);
    reset = 1; jal = 1; j_target = 7;
    apply("reset_jal", 0);
    idle();
    apply("post_reset", 'h04);
    chk("post_reset_empty", int'(ras_empty), 1);
    foreach (tbl[i]) begin
      idle();
      pc_cur = tbl[i].pc; branch = tbl[i].br; zero = tbl[i].z; br_off = tbl[i].off;
      jump = tbl[i].jmp; stall = tbl[i].stl; halt = tbl[i].hlt; j_target = tbl[i].jt;
      apply($sformatf("vec%0d", i), tbl[i].exp);
    end
    idle();
    pc_cur = 'h08; jal = 1; j_target = 5;
    apply("call", 'h14);
    chk("call_nonempty", int'(ras_empty), 0);
    idle();
    pc_cur = 'h14; ret = 1;
    apply("return", 'h0c);
    chk("return_empty", int'(ras_empty), 1);
    for (int i = 0; i < 5; i++) begin
      idle();
      pc_cur = 7'(i * 4); jal = 1; j_target = 1;
      apply("push", 'h04);
    end
    chk("overflow_full", int'(ras_full), 1);
    for (int i = 0; i < 5; i++) begin
      idle();
      pc_cur = 'h40; ret = 1;
      apply("pop", i < 4 ? 'h14 - 4 * i : 0);
    end
    chk("underflow_err", int'(ras_err), 1);
    idle();
    pc_cur = 'h20;
    apply("err_sticky", 'h24);
    chk("err_sticky_lit", int'(ras_err), 1);
    idle();
    reset = 1;
    apply("rst2", 0);
    idle();
    pc_cur = 'h20; stall = 1; jal = 1; j_target = 3;
    apply("stall_jal", 'h20);
    chk("stall_ras", int'(ras_empty), 1);
    idle();
    pc_cur = 'h20; halt = 1;
    apply("halt", 'h20);
    chk("halted_lit", int'(halted), 1);
    idle();
    pc_cur = 'h30; jal = 1; j_target = 2;
    apply("halted_hold", 'h30);
    chk("halted_ras", int'(ras_empty), 1);
    idle();
    reset = 1;
    apply("rst3", 0);
    chk("unhalted", int'(halted), 0);
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = $urandom_range(0, 59) == 0;
      halt = $urandom_range(0, 149) == 0;
      stall = $urandom_range(0, 7) == 0;
      ret = $urandom_range(0, 3) == 0;
      jal = $urandom_range(0, 3) == 0;
      jump = $urandom_range(0, 7) == 0;
      branch = $urandom_range(0, 2) == 0;
      zero = 1'($urandom);
      br_off = 5'($urandom);
      j_target = 5'($urandom);
      pc_cur = {5'($urandom), 2'b00};
      apply("rand", -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
